// File: rtl/btn_pkg.sv
// ============================================================================
// btn_pkg : shared button indices, channel state encoding and width helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package btn_pkg;

    localparam int BTN_NUM   = 6;
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_ENTER = 4;
    localparam int BTN_ESC   = 5;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_t;

    // Counter width sized for the largest timing parameter, never below 1 bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce_ch.sv
// ============================================================================
// btn_debounce_ch : one button channel - 2-flop synchronizer, debounce FSM,
// saturating counters. Optional auto-repeat when BTN_AUTOREPEAT_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 15
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 100000,
    parameter bit REPEAT_EN       = 1'b0
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    btn_state_t       r_state;
    btn_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_level;
    logic             w_level_nxt;
    logic             r_press;
    logic             w_press_nxt;
    logic             w_pressed;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] r_rpt_cnt;
    logic [CNT_W-1:0] w_rpt_cnt_nxt;
    logic [CNT_W-1:0] w_rpt_inc;
    logic             r_rpt_rep;
    logic             w_rpt_rep_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            r_rpt_cnt <= '0;
            r_rpt_rep <= 1'b0;
`endif
        end else begin
            r_sync1   <= btn_n;
            r_sync2   <= r_sync1;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
`ifdef BTN_AUTOREPEAT_EN
            r_rpt_cnt <= w_rpt_cnt_nxt;
            r_rpt_rep <= w_rpt_rep_nxt;
`endif
        end
    end

    // Decisions use the incremented count so the pulse lands DEBOUNCE_CYCLES+2
    // edges after the raw input first reads low.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_pressed     = ~r_sync2;
        w_cnt_inc     = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
`ifdef BTN_AUTOREPEAT_EN
        w_rpt_cnt_nxt = r_rpt_cnt;
        w_rpt_rep_nxt = r_rpt_rep;
        w_rpt_inc     = (r_rpt_cnt == '1) ? r_rpt_cnt : r_rpt_cnt + 1'b1;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_pressed) begin
                    w_state_nxt = ST_PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!w_pressed) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_cnt_inc >= DB_LAST) begin
                    w_state_nxt   = ST_HELD;
                    w_level_nxt   = 1'b1;
                    w_press_nxt   = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                    w_rpt_cnt_nxt = '0;
                    w_rpt_rep_nxt = 1'b0;
`endif
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_HELD: begin
                if (!w_pressed) begin
                    w_state_nxt = ST_RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
`ifdef BTN_AUTOREPEAT_EN
                // Repeat timer only advances here, so RELEASE_WAIT pauses it.
                else if (REPEAT_EN) begin
                    if (r_rpt_cnt == (r_rpt_rep ? PERIOD_LAST : DELAY_LAST)) begin
                        w_press_nxt   = ~r_press;
                        w_rpt_cnt_nxt = '0;
                        w_rpt_rep_nxt = 1'b1;
                    end else begin
                        w_rpt_cnt_nxt = w_rpt_inc;
                    end
                end
`endif
            end
            ST_RELEASE_WAIT: begin
                if (w_pressed) begin
                    w_state_nxt = ST_HELD;
                end else if (w_cnt_inc >= DB_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_level_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign level = r_level;
    assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// button_conditioner : debounces six active-low buttons into held levels and
// press pulses. Auto-repeat on REPEAT_MASK channels when BTN_AUTOREPEAT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module button_conditioner
    import btn_pkg::*;
#(
    parameter int                 DEBOUNCE_CYCLES = 20000,
    parameter int                 REPEAT_DELAY    = 500000,
    parameter int                 REPEAT_PERIOD   = 100000,
    parameter logic [BTN_NUM-1:0] REPEAT_MASK     = 6'b000011
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BTN_NUM-1:0] btn_n,
    output logic [BTN_NUM-1:0] btn_level,
    output logic [BTN_NUM-1:0] btn_press
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

    generate
        for (genvar i = 0; i < BTN_NUM; i++) begin : g_ch
            btn_debounce_ch #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
`ifdef BTN_AUTOREPEAT_EN
                ,
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD),
                .REPEAT_EN       (REPEAT_MASK[i])
`endif
            ) u_ch (
                .clk   (clk),
                .rst_n (rst_n),
                .btn_n (btn_n[i]),
                .level (btn_level[i]),
                .press (btn_press[i])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
// tb_button_conditioner : directed table-driven bench for button_conditioner.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_button_conditioner;

    localparam logic [5:0] ALL_UP = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] btn_n;
    logic [5:0] btn_level;
    logic [5:0] btn_press;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [5:0] btn_n;
        logic [5:0] level;
        logic [5:0] press;
    } vec_t;

    vec_t tbl [14];

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3),
        .REPEAT_MASK     (6'b000011)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_n     (btn_n),
        .btn_level (btn_level),
        .btn_press (btn_press)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic [5:0] b);
        btn_n = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(ALL_UP);
    endtask

    initial begin
        int pulses;
        logic [5:0] exp_p;
        logic       bad;

        // Clean press on channel 0 then full release.
        for (int i = 0; i < 8; i++) begin
            tbl[i].btn_n = 6'b111110;
            tbl[i].level = (i >= 5) ? 6'b000001 : 6'b000000;
            tbl[i].press = (i == 5) ? 6'b000001 : 6'b000000;
        end
        for (int i = 8; i < 14; i++) begin
            tbl[i].btn_n = ALL_UP;
            tbl[i].level = (i == 13) ? 6'b000000 : 6'b000001;
            tbl[i].press = 6'b000000;
        end

        btn_n = ALL_UP;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_level", 32'(btn_level), 32'h0);
        check("reset_press", 32'(btn_press), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            tick(tbl[i].btn_n);
            check($sformatf("clean_level_e%0d", i + 1), 32'(btn_level), 32'(tbl[i].level));
            check($sformatf("clean_press_e%0d", i + 1), 32'(btn_press), 32'(tbl[i].press));
        end
        idle(3);

        // Bounce on channel 2: final low first sampled at edge 10, pulse at 15.
        pulses = 0;
        for (int e = 1; e <= 20; e++) begin
            tick((e == 3 || e == 6 || e == 9) ? ALL_UP : 6'b111011);
            if (btn_press[2]) pulses++;
            check($sformatf("bounce_press_e%0d", e), 32'(btn_press[2]), 32'(e == 15));
        end
        check("bounce_pulse_count", 32'(pulses), 32'd1);
        check("bounce_level", 32'(btn_level[2]), 32'd1);
        idle(8);
        check("bounce_released", 32'(btn_level), 32'h0);

        // Release glitch on channel 4.
        for (int e = 1; e <= 6; e++) tick(6'b101111);
        check("glitch_first_level", 32'(btn_level[4]), 32'd1);
        tick(6'b101111);
        tick(6'b101111);
        tick(ALL_UP);
        tick(ALL_UP);
        bad = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick(6'b101111);
            if (btn_level[4] !== 1'b1 || btn_press[4] !== 1'b0) bad = 1'b1;
        end
        check("glitch_no_effect", 32'(bad), 32'd0);
        for (int e = 1; e <= 5; e++) tick(ALL_UP);
        check("release_h5_level", 32'(btn_level[4]), 32'd1);
        tick(ALL_UP);
        check("release_h6_level", 32'(btn_level[4]), 32'd0);
        idle(3);

        // Simultaneous presses on channels 1 and 5.
        for (int e = 1; e <= 7; e++) begin
            tick(6'b011101);
            if (e >= 5)
                check($sformatf("simul_press_e%0d", e), 32'(btn_press),
                      (e == 6) ? 32'h22 : 32'h0);
        end
        check("simul_level", 32'(btn_level), 32'h22);
        idle(8);

        // Long hold on channels 0 (repeat-capable) and 2 (not in mask).
        for (int e = 1; e <= 30; e++) begin
            tick(6'b111010);
            exp_p = (e == 6) ? 6'b000101 : 6'b000000;
`ifdef BTN_AUTOREPEAT_EN
            if (e >= 16 && (e - 16) % 3 == 0) exp_p[0] = 1'b1;
`endif
            check($sformatf("hold_press_e%0d", e), 32'(btn_press), 32'(exp_p));
        end
        idle(8);
        check("hold_released", 32'(btn_level), 32'h0);

        // Reset during PRESS_WAIT on channel 3 while channel 0 is HELD.
        for (int e = 1; e <= 6; e++) tick(6'b111110);
        for (int e = 1; e <= 3; e++) tick(6'b110110);
        check("pre_reset_level", 32'(btn_level), 32'h01);
        rst_n = 1'b0;
        #1;
        check("midreset_level", 32'(btn_level), 32'h0);
        check("midreset_press", 32'(btn_press), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick(6'b110110);
            check($sformatf("post_reset_press_e%0d", e), 32'(btn_press),
                  (e == 6) ? 32'h09 : 32'h0);
        end
        check("post_reset_level", 32'(btn_level), 32'h09);
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk, rst_n.
REQ-002 Parameter DEBOUNCE_CYCLES, default 20000, SHALL set the stable-input time: 20 ms at the 1 MHz clk.
REQ-003 Parameter REPEAT_DELAY, default 500000, SHALL set the hold time before the first auto-repeat pulse.
REQ-004 Parameter REPEAT_PERIOD, default 100000, SHALL set the interval between later auto-repeat pulses.
REQ-005 Parameter REPEAT_MASK, default 6'b000011, SHALL select the channels allowed to auto-repeat.
REQ-006 Ports SHALL be, one per line:
  clk        input   1  system clock, rising edge
  rst_n      input   1  asynchronous active-low reset
  btn_n      input   6  raw active-low buttons: bit0 up, 1 down, 2 left, 3 right, 4 enter, 5 esc
  btn_level  output  6  debounced active-high held state per button
  btn_press  output  6  one-clk active-high press (and repeat) pulse per button

Function
REQ-007 Each btn_n bit SHALL pass through a 2-flop synchronizer before any use.
REQ-008 Each channel SHALL run an independent FSM with four states:
  - IDLE
  - PRESS_WAIT
  - HELD
  - RELEASE_WAIT
REQ-009 IDLE SHALL go to PRESS_WAIT when the synced input reads pressed (low), clearing the channel counter.
REQ-010 In PRESS_WAIT, a synced high SHALL return the FSM to IDLE with no output.
REQ-011 In PRESS_WAIT, the counter reaching DEBOUNCE_CYCLES-1 SHALL move the FSM to HELD, assert btn_level and pulse btn_press for exactly one cycle.
REQ-012 For an input held stable low, btn_press SHALL rise DEBOUNCE_CYCLES+2 clk edges after the first edge that samples btn_n low.
REQ-013 HELD SHALL go to RELEASE_WAIT on a synced high; btn_level stays 1.
REQ-014 In RELEASE_WAIT, a synced low SHALL return the FSM to HELD with no btn_press pulse.
REQ-015 In RELEASE_WAIT, the counter reaching DEBOUNCE_CYCLES-1 SHALL move the FSM to IDLE and deassert btn_level.
REQ-016 Counters SHALL be $clog2 of the largest parameter wide and SHALL saturate, never wrap.
REQ-017 Channels SHALL be fully independent; simultaneous presses SHALL produce simultaneous pulses.
REQ-018 btn_press SHALL never be high in two consecutive cycles on one channel.

Reset
REQ-019 Asserting rst_n low SHALL immediately force, with no clk required:
  - every FSM to IDLE
  - every counter to 0
  - all synchronizer flops to 1 (released)
  - btn_level and btn_press to 0
REQ-020 Reset applied mid-press SHALL emit no pulse after deassertion until a full new debounce completes.

Configuration
REQ-021 With BTN_AUTOREPEAT_EN defined, a REPEAT_MASK channel SHALL pulse btn_press REPEAT_DELAY cycles after entering HELD, then every REPEAT_PERIOD cycles while in HELD.
REQ-022 With BTN_AUTOREPEAT_EN defined, RELEASE_WAIT SHALL pause the repeat timer, and returning to HELD SHALL resume it without a reset.
REQ-023 Without BTN_AUTOREPEAT_EN, each press SHALL give exactly one pulse; REPEAT_DELAY, REPEAT_PERIOD and REPEAT_MASK SHALL be ignored and the repeat counter SHALL not be synthesized.

Structure
REQ-024 Shared package btn_pkg SHALL hold:
  - button index constants BTN_UP=0, BTN_DOWN=1, BTN_LEFT=2, BTN_RIGHT=3, BTN_ENTER=4, BTN_ESC=5
  - the channel state enum
  - BTN_NUM=6
REQ-025 One sub-module, btn_debounce_ch, SHALL implement one channel (synchronizer, FSM, counters); it SHALL be instantiated BTN_NUM times.

Verification
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
REQ-026 Clean press: btn_n[0] low and held -> btn_press[0] high for 1 cycle at edge 6, btn_level[0]=1.
REQ-027 Bounce: btn_n[2] toggles low 2 cycles, high 1 cycle, 3 times, then stays low -> exactly one btn_press[2], 6 edges after the final low.
REQ-028 Release glitch: btn_n[4] high for 2 cycles while HELD -> btn_level[4] stays 1, no second pulse; high for 6 cycles -> btn_level[4]=0.
REQ-029 Simultaneous: btn_n[1] and btn_n[5] fall on the same edge -> btn_press[1] and btn_press[5] pulse on the same cycle.
REQ-030 Auto-repeat with BTN_AUTOREPEAT_EN: hold btn_n[0] 30 cycles -> pulses at HELD+0, +10, +13, +16 ...; held btn_n[2] -> one pulse only; without the macro btn_n[0] -> one pulse only.
REQ-031 Reset mid-press: rst_n low during PRESS_WAIT -> outputs 0 at once; after release, no pulse until 6 stable-low edges.
